adxl_spi_responder: RTL and testbench

//  SPI mode-0 slave that answers the ADXL362 register protocol: 0x0A write, 0x0B read, then an address byte and data bytes.
//  It is the device end of the accelerometer link. It serves live or scripted X/Y/Z samples to the on-chip SPI master.
//  It also serves as the synthesizable stand-in for the sensor in loopback builds.

---
 rtl/adxl_spi_pkg.sv | 31 +++
 rtl/adxl_spi_responder_spi_in_sync.sv | 37 +++
 rtl/adxl_spi_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_adxl_spi_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adxl_spi_pkg.sv
// Shared constants for the ADXL362-style SPI link: command bytes, register map and FSM states.
// Used by both the responder (device end) and the on-chip SPI master.
package adxl_spi_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;

    localparam logic [7:0] ADDR_DEVID     = 8'h00;
    localparam logic [7:0] ADDR_STATUS    = 8'h0B;
    localparam logic [7:0] ADDR_X_L       = 8'h0E;
    localparam logic [7:0] ADDR_X_H       = 8'h0F;
    localparam logic [7:0] ADDR_Y_L       = 8'h10;
    localparam logic [7:0] ADDR_Y_H       = 8'h11;
    localparam logic [7:0] ADDR_Z_L       = 8'h12;
    localparam logic [7:0] ADDR_Z_H       = 8'h13;
    localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } spi_state_e;

    // High register byte: sign-extended top nibble of a 12-bit sample.
    function automatic logic [7:0] sample_hi(input logic signed [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

endpackage

// File: rtl/adxl_spi_responder_spi_in_sync.sv
// N-flop synchronizer for an asynchronous SPI pad, followed by one edge-detect flop.
// rise/fall are single-cycle pulses aligned with the synchronized level q.
module spi_in_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_q, sync_d;
    logic         prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
        prev_d = sync_q[N-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {N{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[N-1];
    assign rise = sync_q[N-1] & ~prev_q;
    assign fall = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/adxl_spi_responder.sv
// ADXL362-protocol SPI mode-0 slave: device end of the accelerometer link / loopback sensor model.
// Define ADXL_SPI_AUTOINC_EN to let burst transfers walk consecutive registers.
module adxl_spi_responder
    import adxl_spi_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hAD,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic               sclk,
    input  logic               n_CS,
    input  logic               MOSI,
    output logic               MISO,
    output logic               miso_oe,
    input  logic signed [11:0] x_sample,
    input  logic signed [11:0] y_sample,
    input  logic signed [11:0] z_sample,
    input  logic               sample_valid,
    output logic [7:0]         power_ctl,
    output logic               meas_mode,
    output logic               xact_done,
    output logic               err_bad_cmd
);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk_50), .reset(reset), .d(sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // n_CS idles high, so its chain resets high to avoid a phantom select.
    spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk_50), .reset(reset), .d(n_CS),
        .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk_50), .reset(reset), .d(MOSI),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e         state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         shift_in_q, shift_in_d;
    logic [7:0]         sr_q, sr_d;
    logic [7:0]         addr_q, addr_d;
    logic               is_read_q, is_read_d;
    logic               data_ok_q, data_ok_d;
    logic               load_q, load_d;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic [7:0]         power_ctl_q, power_ctl_d;
    logic               data_ready_q, data_ready_d;
    logic               xact_done_q, xact_done_d;
    logic               err_q, err_d;
    logic signed [11:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d, shadow_z_q, shadow_z_d;
    logic signed [11:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_z_q, snap_z_d;
    logic [7:0]         in_byte;
    logic [7:0]         rd_byte;
    logic               clr_ready;

    assign in_byte = {shift_in_q, mosi_s};

    // data_ok_q gates the map so bytes beyond the first read 0 without auto-increment.
    always_comb begin
        rd_byte = 8'h00;
        if (data_ok_q) begin
            case (addr_q)
                ADDR_DEVID:     rd_byte = DEVID;
                ADDR_STATUS:    rd_byte = {7'b0, data_ready_q};
                ADDR_X_L:       rd_byte = snap_x_q[7:0];
                ADDR_X_H:       rd_byte = sample_hi(snap_x_q);
                ADDR_Y_L:       rd_byte = snap_y_q[7:0];
                ADDR_Y_H:       rd_byte = sample_hi(snap_y_q);
                ADDR_Z_L:       rd_byte = snap_z_q[7:0];
                ADDR_Z_H:       rd_byte = sample_hi(snap_z_q);
                ADDR_POWER_CTL: rd_byte = power_ctl_q;
                default:        rd_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        sr_d         = sr_q;
        addr_d       = addr_q;
        is_read_d    = is_read_q;
        data_ok_d    = data_ok_q;
        load_d       = load_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        power_ctl_d  = power_ctl_q;
        xact_done_d  = 1'b0;
        err_d        = 1'b0;
        clr_ready    = 1'b0;
        shadow_x_d   = shadow_x_q;
        shadow_y_d   = shadow_y_q;
        shadow_z_d   = shadow_z_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_z_d     = snap_z_q;

        if (sample_valid) begin
            shadow_x_d = x_sample;
            shadow_y_d = y_sample;
            shadow_z_d = z_sample;
        end

        if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd7;
            oe_d      = 1'b1;
            miso_d    = 1'b0;
            load_d    = 1'b0;
            data_ok_d = 1'b0;
            snap_x_d  = shadow_x_q;
            snap_y_d  = shadow_y_q;
            snap_z_d  = shadow_z_q;
        end else if (cs_rise) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd7;
            oe_d        = 1'b0;
            miso_d      = 1'b0;
            load_d      = 1'b0;
            xact_done_d = 1'b1;
        end else if (state_q != IDLE && state_q != IGNORE) begin
            if (sclk_rise) begin
                shift_in_d = in_byte[6:0];
                bit_cnt_d  = bit_cnt_q - 3'd1;
                if (bit_cnt_q == 3'd0) begin
                    bit_cnt_d = 3'd7;
                    case (state_q)
                        CMD: begin
                            if (in_byte == CMD_WRITE || in_byte == CMD_READ) begin
                                state_d   = ADDR;
                                is_read_d = (in_byte == CMD_READ);
                            end else begin
                                state_d = IGNORE;
                                err_d   = 1'b1;
                            end
                        end
                        ADDR: begin
                            state_d   = DATA;
                            addr_d    = in_byte;
                            data_ok_d = 1'b1;
                            load_d    = is_read_q;
                        end
                        DATA: begin
                            if (data_ok_q) begin
                                if (!is_read_q && addr_q == ADDR_POWER_CTL)
                                    power_ctl_d = in_byte;
                                if (is_read_q && addr_q == ADDR_Z_H)
                                    clr_ready = 1'b1;
                            end
`ifdef ADXL_SPI_AUTOINC_EN
                            addr_d = addr_q + 8'd1;
`else
                            data_ok_d = 1'b0;
`endif
                            load_d = is_read_q;
                        end
                        default: ;
                    endcase
                end
            end else if (sclk_fall) begin
                if (state_q == DATA && is_read_q) begin
                    if (load_q) begin
                        miso_d = rd_byte[7];
                        sr_d   = {rd_byte[6:0], 1'b0};
                        load_d = 1'b0;
                    end else begin
                        miso_d = sr_q[7];
                        sr_d   = {sr_q[6:0], 1'b0};
                    end
                end else begin
                    miso_d = 1'b0;
                end
            end
        end else if (state_q == IGNORE) begin
            miso_d = 1'b0;
        end

        // A new sample outranks the clear from reading Z_H in the same cycle.
        data_ready_d = data_ready_q;
        if (clr_ready)
            data_ready_d = 1'b0;
        if (sample_valid)
            data_ready_d = 1'b1;
    end

    always_ff @(posedge clk_50) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd7;
            shift_in_q   <= '0;
            sr_q         <= '0;
            addr_q       <= '0;
            is_read_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            load_q       <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            power_ctl_q  <= '0;
            data_ready_q <= 1'b0;
            xact_done_q  <= 1'b0;
            err_q        <= 1'b0;
            shadow_x_q   <= '0;
            shadow_y_q   <= '0;
            shadow_z_q   <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_z_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            sr_q         <= sr_d;
            addr_q       <= addr_d;
            is_read_q    <= is_read_d;
            data_ok_q    <= data_ok_d;
            load_q       <= load_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            power_ctl_q  <= power_ctl_d;
            data_ready_q <= data_ready_d;
            xact_done_q  <= xact_done_d;
            err_q        <= err_d;
            shadow_x_q   <= shadow_x_d;
            shadow_y_q   <= shadow_y_d;
            shadow_z_q   <= shadow_z_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_z_q     <= snap_z_d;
        end
    end

    assign MISO        = miso_q;
    assign miso_oe     = oe_q;
    assign power_ctl   = power_ctl_q;
    assign meas_mode   = (power_ctl_q[1:0] == 2'b10);
    assign xact_done   = xact_done_q;
    assign err_bad_cmd = err_q;

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed bench for adxl_spi_responder: acts as a mode-0 SPI master with hand-computed expectations.
// Expectations for burst reads follow ADXL_SPI_AUTOINC_EN when it is defined for the build.
module tb_adxl_spi_responder;

    logic               clk_50 = 1'b0;
    logic               reset = 1'b0;
    logic               sclk = 1'b0;
    logic               n_CS = 1'b1;
    logic               MOSI = 1'b0;
    logic               MISO, miso_oe, meas_mode, xact_done, err_bad_cmd;
    logic [7:0]         power_ctl;
    logic signed [11:0] x_sample = '0, y_sample = '0, z_sample = '0;
    logic               sample_valid = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int done_cyc = 0;
    int err_cyc  = 0;

    adxl_spi_responder #(.DEVID(8'hAD), .SYNC_STAGES(2)) dut (
        .clk_50(clk_50), .reset(reset), .sclk(sclk), .n_CS(n_CS), .MOSI(MOSI),
        .MISO(MISO), .miso_oe(miso_oe),
        .x_sample(x_sample), .y_sample(y_sample), .z_sample(z_sample),
        .sample_valid(sample_valid), .power_ctl(power_ctl), .meas_mode(meas_mode),
        .xact_done(xact_done), .err_bad_cmd(err_bad_cmd)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        if (xact_done)   done_cyc <= done_cyc + 1;
        if (err_bad_cmd) err_cyc  <= err_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One byte (or its first nbits) MSB-first; MISO sampled just before each rising edge.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            #80;
            rx[i] = MISO;
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        n_CS = 1'b0;
        #160;
    endtask

    task automatic cs_high();
        #160;
        n_CS = 1'b1;
        #200;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
        logic [7:0] dummy;
        cs_low();
        xfer(8'h0B, 8, dummy);
        xfer(a, 8, dummy);
        xfer(8'h00, 8, v);
        cs_high();
    endtask

    task automatic pulse_sample();
        @(negedge clk_50);
        sample_valid = 1'b1;
        @(negedge clk_50);
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] burst [6];
        logic [7:0] exp_burst [6];

        repeat (4) @(negedge clk_50);
        reset = 1'b1;
        @(negedge clk_50);
        check("rst_miso", MISO, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_power_ctl", power_ctl, 8'h00);
        check("rst_meas_mode", meas_mode, 1'b0);
        check("rst_xact_done", xact_done, 1'b0);
        check("rst_err", err_bad_cmd, 1'b0);

        // 1: DEVID read, xact_done pulse
        cs_low();
        check("t1_oe_active", miso_oe, 1'b1);
        xfer(8'h0B, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx);
        check("t1_done_before_rise", done_cyc, 0);
        cs_high();
        check("t1_devid", rx, 8'hAD);
        check("t1_done_pulse", done_cyc, 1);
        check("t1_miso_idle", MISO, 1'b0);
        check("t1_oe_idle", miso_oe, 1'b0);

        // 2: write POWER_CTL=0x02, read back
        cs_low();
        xfer(8'h0A, 8, rx);
        xfer(8'h2D, 8, rx);
        xfer(8'h02, 8, rx);
        #40;
        check("t2_power_ctl", power_ctl, 8'h02);
        check("t2_meas_mode", meas_mode, 1'b1);
        cs_high();
        read_reg(8'h2D, rx);
        check("t2_readback", rx, 8'h02);

        // 3: sample capture and burst read from X_L
        x_sample = 12'sh123;
        y_sample = 12'shFFF;
        z_sample = 12'sh800;
        pulse_sample();
        read_reg(8'h0B, rx);
        check("t3_status_set", rx, 8'h01);
`ifdef ADXL_SPI_AUTOINC_EN
        exp_burst = '{8'h23, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'hF8};
`else
        exp_burst = '{8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        cs_low();
        xfer(8'h0B, 8, rx);
        xfer(8'h0E, 8, rx);
        for (int i = 0; i < 6; i++) xfer(8'h00, 8, burst[i]);
        cs_high();
        for (int i = 0; i < 6; i++) check($sformatf("t3_burst%0d", i), burst[i], exp_burst[i]);
`ifdef ADXL_SPI_AUTOINC_EN
        read_reg(8'h0B, rx);
        check("t3_status_clr", rx, 8'h00);
`else
        read_reg(8'h0B, rx);
        check("t3_status_kept", rx, 8'h01);
        read_reg(8'h13, rx);
        check("t3_z_h", rx, 8'hF8);
        read_reg(8'h0B, rx);
        check("t3_status_clr", rx, 8'h00);
`endif

        // 4: bad command goes to IGNORE
        cs_low();
        xfer(8'h55, 8, rx);
        #40;
        check("t4_err_pulse", err_cyc, 1);
        xfer(8'h2D, 8, rx);
        check("t4_miso_b1", rx, 8'h00);
        xfer(8'h07, 8, rx);
        check("t4_miso_b2", rx, 8'h00);
        cs_high();
        check("t4_power_ctl", power_ctl, 8'h02);
        check("t4_err_once", err_cyc, 1);

        // 5: aborted write after 4 data bits
        cs_low();
        xfer(8'h0A, 8, rx);
        xfer(8'h2D, 8, rx);
        xfer(8'hF3, 4, rx);
        cs_high();
        check("t5_power_ctl", power_ctl, 8'h02);
        check("t5_oe_idle", miso_oe, 1'b0);
        read_reg(8'h00, rx);
        check("t5_devid", rx, 8'hAD);

        // 6: new sample mid-burst only reaches the next transaction
        cs_low();
        xfer(8'h0B, 8, rx);
        xfer(8'h0E, 8, rx);
        x_sample = 12'sh7FF;
        pulse_sample();
        xfer(8'h00, 8, burst[0]);
        xfer(8'h00, 8, burst[1]);
        cs_high();
        check("t6_old_x_l", burst[0], 8'h23);
`ifdef ADXL_SPI_AUTOINC_EN
        check("t6_old_x_h", burst[1], 8'h01);
`else
        check("t6_old_x_h", burst[1], 8'h00);
`endif
        cs_low();
        xfer(8'h0B, 8, rx);
        xfer(8'h0E, 8, rx);
        xfer(8'h00, 8, burst[0]);
        xfer(8'h00, 8, burst[1]);
        cs_high();
        check("t6_new_x_l", burst[0], 8'hFF);
`ifdef ADXL_SPI_AUTOINC_EN
        check("t6_new_x_h", burst[1], 8'h07);
`else
        check("t6_new_x_h", burst[1], 8'h00);
`endif
        check("t6_err_total", err_cyc, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
